// File: rtl/hbm_edge_rqst_gen.sv
// Edge-request generator: expands one (offset, degree) vertex descriptor into
// ascending HBM line-read requests with per-line lane masks and vertex tags.
module hbm_edge_rqst_gen #(
    parameter int V_ID_WIDTH   = 32,
    parameter int V_OFF_DWIDTH = 32,
    parameter int HBM_AWIDTH   = 32,
    parameter int EPL_WIDTH    = 3,
    parameter int EPL          = 1 << EPL_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [V_ID_WIDTH-1:0]   active_v_id,
    input  logic [V_OFF_DWIDTH-1:0] active_v_off,
    input  logic [V_OFF_DWIDTH-1:0] active_v_deg,
    input  logic                    active_v_valid,
    output logic                    active_v_ready,
    input  logic                    stage_full,
    output logic [HBM_AWIDTH-1:0]   front_rd_hbm_edge_addr,
    output logic                    front_rd_hbm_edge_valid,
    output logic [V_ID_WIDTH-1:0]   front_rd_hbm_edge_vid,
    output logic [EPL-1:0]          front_rd_hbm_edge_mask,
    output logic                    front_rd_hbm_edge_last,
    output logic                    busy
);

    // Line indices keep one extra bit so the end line of a descriptor that
    // runs past the top of the offset space does not wrap.
    localparam int LW = V_OFF_DWIDTH + 1 - EPL_WIDTH;
    localparam logic [LW-1:0] LINE_ONE = {{(LW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                  r_state;
    logic [LW-1:0]           r_cur_line;
    logic [LW-1:0]           r_end_line;
    logic [EPL_WIDTH-1:0]    r_s_lane;
    logic [EPL_WIDTH-1:0]    r_e_lane;
    logic                    r_first;
    logic [V_ID_WIDTH-1:0]   r_vid;
    logic                    r_valid;
    logic [HBM_AWIDTH-1:0]   r_addr;
    logic [V_ID_WIDTH-1:0]   r_out_vid;
    logic [EPL-1:0]          r_mask;
    logic                    r_last;

    logic [V_OFF_DWIDTH:0]   w_end_off;
    logic [LW-1:0]           w_start_line;
    logic                    w_accept;
    logic                    w_is_last;
    logic                    w_deg_zero;

    function automatic logic [EPL-1:0] f_lane_mask(
        input logic                 first,
        input logic                 last,
        input logic [EPL_WIDTH-1:0] s_lane,
        input logic [EPL_WIDTH-1:0] e_lane
    );
        logic [EPL-1:0] m;
        m = {EPL{1'b1}};
        for (int k = 0; k < EPL; k++) begin
            if (first && (EPL_WIDTH'(k) < s_lane)) begin
                m[k] = 1'b0;
            end else if (last && (EPL_WIDTH'(k) > e_lane)) begin
                m[k] = 1'b0;
            end else begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

    assign w_end_off    = {1'b0, active_v_off} + {1'b0, active_v_deg}
                        - {{V_OFF_DWIDTH{1'b0}}, 1'b1};
    assign w_start_line = {1'b0, active_v_off[V_OFF_DWIDTH-1:EPL_WIDTH]};
    assign w_deg_zero   = (active_v_deg == {V_OFF_DWIDTH{1'b0}});
    assign w_accept     = active_v_valid && active_v_ready;
    assign w_is_last    = (r_cur_line == r_end_line);

    assign active_v_ready          = (r_state == S_IDLE) && !rst;
    assign busy                    = (r_state != S_IDLE) || r_valid;
    assign front_rd_hbm_edge_valid = r_valid;
    assign front_rd_hbm_edge_addr  = r_addr;
    assign front_rd_hbm_edge_vid   = r_out_vid;
    assign front_rd_hbm_edge_mask  = r_mask;
    assign front_rd_hbm_edge_last  = r_last;

    // Descriptor capture, per-line request issue and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cur_line <= {LW{1'b0}};
            r_end_line <= {LW{1'b0}};
            r_s_lane   <= {EPL_WIDTH{1'b0}};
            r_e_lane   <= {EPL_WIDTH{1'b0}};
            r_first    <= 1'b0;
            r_vid      <= {V_ID_WIDTH{1'b0}};
            r_valid    <= 1'b0;
            r_addr     <= {HBM_AWIDTH{1'b0}};
            r_out_vid  <= {V_ID_WIDTH{1'b0}};
            r_mask     <= {EPL{1'b0}};
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    // A zero-degree descriptor is consumed without leaving IDLE.
                    if (w_accept && !w_deg_zero) begin
                        r_cur_line <= w_start_line;
                        r_end_line <= w_end_off[V_OFF_DWIDTH:EPL_WIDTH];
                        r_s_lane   <= active_v_off[EPL_WIDTH-1:0];
                        r_e_lane   <= w_end_off[EPL_WIDTH-1:0];
                        r_first    <= 1'b1;
                        r_vid      <= active_v_id;
                        r_state    <= S_ISSUE;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (stage_full) begin
                        r_valid <= 1'b0;
                    end else begin
                        r_valid    <= 1'b1;
                        r_addr     <= HBM_AWIDTH'(r_cur_line);
                        r_mask     <= f_lane_mask(r_first, w_is_last, r_s_lane, r_e_lane);
                        r_last     <= w_is_last;
                        r_out_vid  <= r_vid;
                        r_cur_line <= r_cur_line + LINE_ONE;
                        r_first    <= 1'b0;
                        if (w_is_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hbm_edge_rqst_gen.sv
// Directed bench for hbm_edge_rqst_gen: table of vertex descriptors with
// hand-computed request streams, plus stall and mid-vertex reset sequences.
module tb_hbm_edge_rqst_gen;

    logic        clk;
    logic        rst;
    logic [31:0] active_v_id;
    logic [31:0] active_v_off;
    logic [31:0] active_v_deg;
    logic        active_v_valid;
    logic        active_v_ready;
    logic        stage_full;
    logic [31:0] front_rd_hbm_edge_addr;
    logic        front_rd_hbm_edge_valid;
    logic [31:0] front_rd_hbm_edge_vid;
    logic [7:0]  front_rd_hbm_edge_mask;
    logic        front_rd_hbm_edge_last;
    logic        busy;

    int checks;
    int errors;

    hbm_edge_rqst_gen dut (
        .clk                     (clk),
        .rst                     (rst),
        .active_v_id             (active_v_id),
        .active_v_off            (active_v_off),
        .active_v_deg            (active_v_deg),
        .active_v_valid          (active_v_valid),
        .active_v_ready          (active_v_ready),
        .stage_full              (stage_full),
        .front_rd_hbm_edge_addr  (front_rd_hbm_edge_addr),
        .front_rd_hbm_edge_valid (front_rd_hbm_edge_valid),
        .front_rd_hbm_edge_vid   (front_rd_hbm_edge_vid),
        .front_rd_hbm_edge_mask  (front_rd_hbm_edge_mask),
        .front_rd_hbm_edge_last  (front_rd_hbm_edge_last),
        .busy                    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] off;
        logic [31:0] deg;
        logic [31:0] vid;
        int          n;
        logic [31:0] a0;
        logic [7:0]  m0;
        logic [7:0]  ml;
    } vec_t;

    localparam int NVEC = 8;
    localparam int WIN  = 12;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_desc(input logic [31:0] off, input logic [31:0] deg, input logic [31:0] vid);
        @(negedge clk);
        check("ready_before_accept", {63'd0, active_v_ready}, 64'd1);
        active_v_off   = off;
        active_v_deg   = deg;
        active_v_id    = vid;
        active_v_valid = 1'b1;
        @(negedge clk);
        active_v_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int          n_seen;
        int          first_idx;
        int          busy_hi;
        int          ready_lo;
        logic [7:0]  exp_mask;
        n_seen    = 0;
        first_idx = -1;
        busy_hi   = 0;
        ready_lo  = 0;
        drive_desc(v.off, v.deg, v.vid);
        for (int idx = 0; idx < WIN; idx++) begin
            if (idx > 0) @(negedge clk);
            if (busy) busy_hi++;
            if (!active_v_ready) ready_lo++;
            if (front_rd_hbm_edge_valid) begin
                if (n_seen == 0) first_idx = idx;
                if (n_seen == 0) exp_mask = v.m0;
                else if (n_seen == v.n - 1) exp_mask = v.ml;
                else exp_mask = 8'hFF;
                check("addr", {32'd0, front_rd_hbm_edge_addr}, {32'd0, v.a0 + 32'(n_seen)});
                check("mask", {56'd0, front_rd_hbm_edge_mask}, {56'd0, exp_mask});
                check("last", {63'd0, front_rd_hbm_edge_last}, {63'd0, (n_seen == v.n - 1)});
                check("vid", {32'd0, front_rd_hbm_edge_vid}, {32'd0, v.vid});
                if (front_rd_hbm_edge_last)
                    check("ready_after_last", {63'd0, active_v_ready}, 64'd1);
                n_seen++;
            end
        end
        check("req_count", 64'(n_seen), 64'(v.n));
        if (v.n > 0) check("first_latency", 64'(first_idx), 64'd1);
        else begin
            check("deg0_busy_cycles", 64'(busy_hi), 64'd0);
            check("deg0_ready_low_cycles", 64'(ready_lo), 64'd0);
        end
        check("busy_idle", {63'd0, busy}, 64'd0);
        check("ready_idle", {63'd0, active_v_ready}, 64'd1);
    endtask

    initial begin
        int          n_seen;
        int          line2_idx;
        int          stall_valid;
        int          resid;
        logic [31:0] exp_addr;

        checks = 0;
        errors = 0;
        vecs[0] = '{off: 32'd5,          deg: 32'd6,  vid: 32'h11, n: 2, a0: 32'd0,          m0: 8'hE0, ml: 8'h07};
        vecs[1] = '{off: 32'd16,         deg: 32'd8,  vid: 32'h22, n: 1, a0: 32'd2,          m0: 8'hFF, ml: 8'hFF};
        vecs[2] = '{off: 32'd0,          deg: 32'd0,  vid: 32'h07, n: 0, a0: 32'd0,          m0: 8'h00, ml: 8'h00};
        vecs[3] = '{off: 32'd0,          deg: 32'd40, vid: 32'h33, n: 5, a0: 32'd0,          m0: 8'hFF, ml: 8'hFF};
        vecs[4] = '{off: 32'hFFFF_FFFC,  deg: 32'd4,  vid: 32'h44, n: 1, a0: 32'h1FFF_FFFF, m0: 8'hF0, ml: 8'hF0};
        vecs[5] = '{off: 32'd3,          deg: 32'd1,  vid: 32'h55, n: 1, a0: 32'd0,          m0: 8'h08, ml: 8'h08};
        vecs[6] = '{off: 32'd7,          deg: 32'd10, vid: 32'h66, n: 3, a0: 32'd0,          m0: 8'h80, ml: 8'h01};
        vecs[7] = '{off: 32'hFFFF_FFFF,  deg: 32'd2,  vid: 32'h77, n: 2, a0: 32'h1FFF_FFFF, m0: 8'h80, ml: 8'h01};

        rst            = 1'b1;
        active_v_id    = 32'd0;
        active_v_off   = 32'd0;
        active_v_deg   = 32'd0;
        active_v_valid = 1'b0;
        stage_full     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {63'd0, front_rd_hbm_edge_valid}, 64'd0);
        check("rst_addr", {32'd0, front_rd_hbm_edge_addr}, 64'd0);
        check("rst_mask", {56'd0, front_rd_hbm_edge_mask}, 64'd0);
        check("rst_vid", {32'd0, front_rd_hbm_edge_vid}, 64'd0);
        check("rst_last", {63'd0, front_rd_hbm_edge_last}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, active_v_ready}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // Stall: stage_full high for three cycles right after the second request.
        n_seen      = 0;
        line2_idx   = -1;
        stall_valid = 0;
        drive_desc(32'd0, 32'd40, 32'h88);
        for (int idx = 0; idx < 16; idx++) begin
            if (idx > 0) @(negedge clk);
            if (front_rd_hbm_edge_valid) begin
                if (idx >= 3 && idx <= 5) stall_valid++;
                if (n_seen == 2) line2_idx = idx;
                check("stall_addr", {32'd0, front_rd_hbm_edge_addr}, 64'(n_seen));
                check("stall_mask", {56'd0, front_rd_hbm_edge_mask}, 64'hFF);
                check("stall_last", {63'd0, front_rd_hbm_edge_last}, {63'd0, (n_seen == 4)});
                n_seen++;
            end
            if (idx == 2) stage_full = 1'b1;
            if (idx == 5) stage_full = 1'b0;
        end
        check("stall_count", 64'(n_seen), 64'd5);
        check("stall_valid_while_full", 64'(stall_valid), 64'd0);
        check("stall_resume_idx", 64'(line2_idx), 64'd6);

        // Reset asserted while the third line of a 64-edge vertex is visible.
        drive_desc(32'd0, 32'd64, 32'h99);
        repeat (3) @(negedge clk);
        check("pre_rst_valid", {63'd0, front_rd_hbm_edge_valid}, 64'd1);
        exp_addr = 32'd2;
        check("pre_rst_addr", {32'd0, front_rd_hbm_edge_addr}, {32'd0, exp_addr});
        rst = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, front_rd_hbm_edge_valid}, 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_ready", {63'd0, active_v_ready}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {63'd0, active_v_ready}, 64'd1);
        resid = 0;
        for (int idx = 0; idx < WIN; idx++) begin
            @(negedge clk);
            if (front_rd_hbm_edge_valid) resid++;
        end
        check("post_rst_residual", 64'(resid), 64'd0);
        check("post_rst_busy", {63'd0, busy}, 64'd0);

        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hbm_edge_rqst_gen.md
Name: hbm_edge_rqst_gen

Overview:
Per-pseudo-channel edge-request generator, sitting directly upstream of the HBM send-request stage. It takes one active vertex per handshake, given as an edge-list start offset and a degree, and expands it into a stream of HBM line-read requests, one line per cycle. It honours that stage's `stage_full` backpressure. Each request carries a lane mask and a vertex tag so the receive side can discard edges that belong to neighbouring vertices in the same line.

Parameters:
- V_ID_WIDTH, 32, vertex id width.
- V_OFF_DWIDTH, 32, edge-offset and degree width.
- HBM_AWIDTH, 32, HBM line-address width (relative line index; the send stage adds the channel base).
- EPL_WIDTH, 3, log2 of edges per HBM line (8 edges of 32 b in 256 b).
- EPL, 1<<EPL_WIDTH, edges per line.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- active_v_id  in  V_ID_WIDTH  vertex id.
- active_v_off  in  V_OFF_DWIDTH  first edge offset.
- active_v_deg  in  V_OFF_DWIDTH  edge count.
- active_v_valid  in  1  vertex descriptor valid.
- active_v_ready  out  1  descriptor accepted when valid&&ready.
- stage_full  in  1  downstream prog_full; no request may be issued while high.
- front_rd_hbm_edge_addr  out  HBM_AWIDTH  line index.
- front_rd_hbm_edge_valid  out  1  request strobe, single cycle per line.
- front_rd_hbm_edge_vid  out  V_ID_WIDTH  owning vertex id.
- front_rd_hbm_edge_mask  out  EPL  valid-lane mask; bit k = edge lane k.
- front_rd_hbm_edge_last  out  1  final line of this vertex.
- busy  out  1  state != IDLE or a request is in the output register.

Behaviour:
- FSM has two states, IDLE and ISSUE. `active_v_ready` = (state==IDLE) && !rst (combinational).
- **Accept in IDLE:**
  - If deg==0: the descriptor is consumed, no request is issued, and the FSM stays in IDLE.
  - Else:
    - end_off = off + deg - 1, computed at V_OFF_DWIDTH+1 bits with no wrap.
    - cur_line = off >> EPL_WIDTH; end_line = end_off >> EPL_WIDTH.
    - s_lane = off[EPL_WIDTH-1:0]; e_lane = end_off[EPL_WIDTH-1:0].
    - first = 1; latch vid; go to ISSUE.
- **ISSUE, per cycle:**
  - If stage_full==1: valid register loads 0; all state is held.
  - Else, register the following:
    - valid = 1; addr = cur_line, truncated/zero-extended to HBM_AWIDTH.
    - mask = all ones, with bits < s_lane cleared if first, and bits > e_lane cleared if cur_line==end_line.
    - last = (cur_line==end_line); vid = latched vid.
    - Then cur_line++ and first = 0. If last, go to IDLE.
- All outputs are registered. For an accept in cycle t (no stall), the first request is valid in cycle t+2.
- Throughput is one line per cycle. Back-to-back vertices incur exactly one bubble cycle (the IDLE accept cycle).
- When valid=0, addr/mask/vid/last hold their previous values; the consumer ignores them.
- stage_full is sampled in the same cycle: a high value in cycle c suppresses the request that would be visible in cycle c+1. No request is dropped or duplicated across a stall.
- Single-line vertex (cur_line==end_line at accept): one request; the mask applies both the s_lane and e_lane bounds; last=1.
- Lines are emitted in strictly ascending order. Every edge in [off, off+deg-1] appears in exactly one mask bit, and no other edge does.
- **Reset** (async assert, sync deassert by the environment):
  - State = IDLE.
  - front_rd_hbm_edge_valid/addr/vid/mask/last = 0; busy = 0; active_v_ready = 0 while rst=1.
  - Internal registers are cleared.
  - Reset mid-ISSUE aborts the vertex; no further requests for it are issued after deassertion.

Test Plan:
- EPL=8, off=5, deg=6, stage_full=0 → two requests: addr 0 mask 0xE0 last 0, then addr 1 mask 0x07 last 1; first one at t+2.
- off=16, deg=8 → one request: addr 2, mask 0xFF, last 1; ready returns 1 the cycle after it issues.
- deg=0, vid=7 → descriptor consumed, no valid pulse, ready stays 1, busy stays 0.
- off=0, deg=40, stage_full held high for 3 cycles after the second request → addrs 0..4 each exactly once, all masks 0xFF, last only on addr 4; no valid while stalled + 1 cycle.
- Assert rst during the third line of a deg=64 vertex → valid drops to 0 asynchronously in the same cycle; after deassertion ready=1 and no residual requests.
- off=2^32-4, deg=4 → single request addr 0x1FFFFFFF, mask 0xF0, last 1 (no overflow wrap in end_off).
